sha_digest_stream: RTL and testbench
====================================

# sha_digest_stream

Downstream output stage of the SHA core. Captures the `Nk`-bit digest on the core's one-cycle `Ready` pulse and emits it most-significant word first as a stream of `Nw`-bit words over a valid/ready handshake. The SHA core can start the next message while this block drains the previous digest.

## Interface

- `Nk`, default 256: digest width in bits, matching the SHA core's `Hash` port (160, 256 or 512); `Nk % Nw == 0` is required.
- `Nw`, default 8: output word width in bits (8 or 32).
- Derived: `Nd = Nk/Nw` words per digest; count width `Nc = $clog2(Nd)`.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst==0` resets immediately).
- `Hash`  in  Nk  digest from the SHA core; sampled only in the cycle `Ready==1`.
- `Ready`  in  1  one-cycle digest-valid pulse from the SHA core.
- `Out_Data`  out  Nw  current output word.
- `Out_Valid`  out  1  `Out_Data` holds a valid word.
- `Out_Ready`  in  1  consumer accepts the word; a transfer happens when `Out_Valid && Out_Ready`.
- `Out_Last`  out  1  the current word is word `Nd-1` of the digest.
- `Busy`  out  1  a digest is held and not yet fully transferred.
- `Overrun`  out  1  sticky: a digest was dropped because the block was busy.

## Operation

- Internal state:
  - `state` ∈ {IDLE, SEND}.
  - Shift register `sreg[Nk-1:0]`.
  - Word counter `cnt[Nc-1:0]`.
  - `ovr` flag.
- IDLE, `Ready==1`: `sreg<=Hash`, `cnt<=0`, go to SEND.
- SEND:
  - Outputs: `Out_Valid=1`, `Out_Data=sreg[Nk-1 -: Nw]` (big-endian, digest MSB first), `Out_Last=(cnt==Nd-1)`.
  - On a transfer with `cnt<Nd-1`: `sreg<=sreg<<Nw`, `cnt<=cnt+1`.
  - On a transfer with `cnt==Nd-1` and `Ready==0`: return to IDLE, `sreg<=0`.
  - On a transfer with `cnt==Nd-1` and `Ready==1`: capture the new `Hash`, `cnt<=0`, stay in SEND (gapless back-to-back). This is not an overrun.
  - `Ready==1` in any other SEND cycle: the new digest is discarded, `ovr<=1`, and the current stream continues unchanged.
- No transfer in SEND: `sreg`, `cnt`, `Out_Data` and `Out_Last` hold.
- IDLE outputs: `Out_Valid=0`, `Out_Data=0`, `Out_Last=0`.
- `Busy=(state==SEND)`; `Overrun=ovr`. `ovr` is cleared only by reset.
- `Out_Ready` is ignored while `Out_Valid==0`.

## Timing

- Reset (asynchronous, takes effect without a clock edge):
  - `state=IDLE`, `sreg=0`, `cnt=0`, `ovr=0`.
  - Outputs: `Out_Data=0`, `Out_Valid=0`, `Out_Last=0`, `Busy=0`, `Overrun=0`.
- Latency: `Ready` high at edge t gives `Out_Valid=1` with word 0 from cycle t+1.
- Outputs are registered or decoded from registers only; there is no combinational path from `Ready` or `Out_Ready` to any output.
- Throughput: with `Out_Ready` held at 1, words 0..Nd-1 appear in cycles t+1..t+Nd. `Busy` falls after the edge ending cycle t+Nd.
- Handshake rules:
  - While `Out_Valid && !Out_Ready`, `Out_Data` and `Out_Last` are stable.
  - `Out_Valid` never drops before its transfer.
- Reset mid-stream: the stream aborts immediately. The first `Ready` after release restarts at word 0.

## Test plan

- Nk=256, Nw=8, `Hash` = SHA-256("abc") = ba7816bf…f20015ad, `Ready` pulse, `Out_Ready=1`:
  - Bytes ba,78,16,bf,…,15,ad appear in cycles t+1..t+32.
  - `Out_Last` is high only at t+32; `Busy` is 0 from t+33.
- Backpressure: same digest with `Out_Ready` toggling 1,0,1,0…:
  - All 32 bytes are delivered in order with none duplicated or skipped.
  - Data is stable during stalls; the stream completes in 63–64 cycles.
- Overrun: second `Ready` pulse with a different `Hash` while byte 5 is pending:
  - The remaining bytes still come from the first digest.
  - `Overrun` rises the next cycle and stays 1 after the stream ends.
- Back-to-back: second `Ready` in the same cycle as the final transfer:
  - In the next cycle `Out_Valid=1` with the new digest's byte 0 (no idle gap).
  - `Overrun` stays 0.
- Reset mid-stream: drop `rst` during byte 10:
  - All outputs go to 0 before the next clock edge.
  - After release, a new `Ready` restarts at byte 0.
- Nk=160, Nw=32, SHA-1("abc"):
  - Words a9993e36, 4706816a, ba3e2571, 7850c26c, 9cd0d89d in 5 consecutive cycles.
  - `Out_Last` is high on the fifth word.

Source files
------------

// File: rtl/sha_digest_stream.sv
// Holds one SHA digest and streams it MSB word first; word 0 is valid the cycle after Ready.
// Out_Ready low stalls the word in place; a Ready that arrives while busy is dropped and flagged in Overrun.
module sha_digest_stream #(
  parameter int Nk = 256,
  parameter int Nw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [Nk-1:0] Hash,
  input  logic          Ready,
  output logic [Nw-1:0] Out_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic          Out_Last,
  output logic          Busy,
  output logic          Overrun
);
  localparam int Nd = Nk / Nw;
  localparam int Nc = (Nd > 1) ? $clog2(Nd) : 1;
  localparam logic [Nc-1:0] LAST_CNT = Nc'(Nd - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        r_state, w_state_nxt;
  logic [Nk-1:0] r_sreg, w_sreg_nxt;
  logic [Nc-1:0] r_cnt, w_cnt_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic          w_xfer;
  logic          w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign w_xfer = (r_state == SEND) && Out_Ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      IDLE: begin
        if (Ready) begin
          w_sreg_nxt  = Hash;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_xfer && !w_last) begin
          w_sreg_nxt = r_sreg << Nw;
          w_cnt_nxt  = r_cnt + 1'b1;
        end else if (w_xfer) begin
          // Final word leaves this cycle: a coincident Ready chains straight into the next digest.
          if (Ready) begin
            w_sreg_nxt = Hash;
            w_cnt_nxt  = '0;
          end else begin
            w_sreg_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        if (Ready && !(w_xfer && w_last)) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Out_Valid = (r_state == SEND);
  assign Out_Data  = (r_state == SEND) ? r_sreg[Nk-1 -: Nw] : '0;
  assign Out_Last  = (r_state == SEND) && w_last;
  assign Busy      = (r_state == SEND);
  assign Overrun   = r_ovr;
endmodule

// File: tb/tb_sha_digest_stream.sv
// Bench for sha_digest_stream: a queue-of-words reference model and known SHA-256/SHA-1 "abc" digests.
module tb_sha_digest_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [255:0] hash;
  logic         ready;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, out_last, busy, overrun;

  logic         rst1;
  logic [159:0] hash1;
  logic         ready1;
  logic [31:0]  out_data1;
  logic         out_valid1, out_ready1, out_last1, busy1, overrun1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  bit         movr;

  localparam logic [255:0] ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [159:0] ABC160 = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  sha_digest_stream #(.Nk(256), .Nw(8)) dut (
    .clk(clk), .rst(rst), .Hash(hash), .Ready(ready),
    .Out_Data(out_data), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Last(out_last), .Busy(busy), .Overrun(overrun)
  );

  sha_digest_stream #(.Nk(160), .Nw(32)) dut1 (
    .clk(clk), .rst(rst1), .Hash(hash1), .Ready(ready1),
    .Out_Data(out_data1), .Out_Valid(out_valid1), .Out_Ready(out_ready1),
    .Out_Last(out_last1), .Busy(busy1), .Overrun(overrun1)
  );

  function automatic logic [7:0] byte_of(input logic [255:0] h, input int k);
    return h[255-8*k -: 8];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [11:0] exp_vec();
    if (mq.size() == 0) return {3'b000, movr, 8'h00};
    return {1'b1, mq.size() == 1, 1'b1, movr, mq[0]};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {out_valid, out_last, busy, overrun, out_data};
  endfunction

  // Model: a digest becomes 32 queued bytes; the head byte is what the consumer should see.
  task automatic step();
    bit was_busy, xfer, fin;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      movr = 1'b0;
    end else begin
      was_busy = (mq.size() > 0);
      xfer     = was_busy && out_ready;
      fin      = xfer && (mq.size() == 1);
      if (xfer) void'(mq.pop_front());
      if (ready) begin
        if (!was_busy || fin) begin
          for (int i = 0; i < 32; i++) mq.push_back(byte_of(hash, i));
        end else begin
          movr = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; rst1 = 1'b0; ready = 1'b0; ready1 = 1'b0;
    out_ready = 1'b0; out_ready1 = 1'b0; hash = '0; hash1 = '0;
    #2;
    n_vec++;
    if (obs_vec() !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 12'h000);
    end
    n_vec++;
    if ({out_valid1, out_last1, busy1, overrun1, out_data1} !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs_w32: got %h expected 0", {out_valid1, out_last1, busy1, overrun1, out_data1});
    end
    step();
    rst = 1'b1; rst1 = 1'b1;
    step();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL idle_after_reset: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_abc_stream();
    logic [255:0] ref_h;
    ref_h = ABC256;
    hash = ABC256; ready = 1'b1; out_ready = 1'b1;
    step();
    ready = 1'b0; hash = rand256();
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL abc_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({out_valid, out_last, out_data} !== {1'b1, k == 31, byte_of(ref_h, k)}) begin
        n_err++; $display("FAIL abc_byte k=%0d: got v%b l%b %h expected v1 l%0d %h",
                          k, out_valid, out_last, out_data, k == 31, byte_of(ref_h, k));
      end
      step();
    end
    n_vec++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL abc_done: got busy=%b valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] ref_h;
    logic [7:0]   got[$];
    int           cyc;
    ref_h = ABC256;
    hash = ABC256; ready = 1'b1; out_ready = 1'b1;
    step();
    ready = 1'b0;
    cyc = 0;
    while (cyc < 100 && got.size() < 32) begin
      cyc++;
      out_ready = (cyc % 2 == 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL bp_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
    n_vec++;
    if (got.size() != 32 || cyc < 63 || cyc > 64) begin
      n_err++; $display("FAIL bp_length: got %0d bytes in %0d cycles expected 32 in 63-64", got.size(), cyc);
    end
    for (int k = 0; k < 32 && k < got.size(); k++) begin
      n_vec++;
      if (got[k] !== byte_of(ref_h, k)) begin
        n_err++; $display("FAIL bp_order k=%0d: got %h expected %h", k, got[k], byte_of(ref_h, k));
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL bp_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a, b;
    bit           fired;
    int           cyc;
    a = rand256(); b = rand256();
    hash = a; ready = 1'b1; out_ready = 1'b1;
    step();
    ready = 1'b0; fired = 1'b0; cyc = 0;
    while (!fired && cyc < 200) begin
      cyc++;
      if (mq.size() == 1) begin
        out_ready = 1'b1; ready = 1'b1; hash = b; fired = 1'b1;
      end else begin
        out_ready = $urandom_range(0, 1);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL b2b_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
    ready = 1'b0;
    n_vec++;
    if ({fired, out_valid, out_last, overrun, out_data} !== {4'b1100, byte_of(b, 0)}) begin
      n_err++; $display("FAIL b2b_chain: got fired%b v%b l%b ovr%b %h expected 1 1 0 0 %h",
                        fired, out_valid, out_last, overrun, out_data, byte_of(b, 0));
    end
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      out_ready = $urandom_range(0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL b2b_drain cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
    n_vec++;
    if ({busy, overrun} !== 2'b00) begin
      n_err++; $display("FAIL b2b_end: got busy=%b ovr=%b expected 0 0", busy, overrun);
    end
  endtask

  task automatic test_overrun();
    logic [255:0] a, b;
    int           cyc;
    a = rand256(); b = ~a;
    hash = a; ready = 1'b1; out_ready = 1'b1;
    step();
    ready = 1'b0;
    while (mq.size() > 27) step();
    n_vec++;
    if ({out_valid, overrun, out_data} !== {2'b10, byte_of(a, 5)}) begin
      n_err++; $display("FAIL ovr_pending5: got v%b ovr%b %h expected 1 0 %h", out_valid, overrun, out_data, byte_of(a, 5));
    end
    hash = b; ready = 1'b1; out_ready = $urandom_range(0, 1);
    step();
    ready = 1'b0;
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_rise: got %b expected 1", overrun);
    end
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      out_ready = $urandom_range(0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ovr_drain cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
    n_vec++;
    if ({busy, overrun} !== 2'b01) begin
      n_err++; $display("FAIL ovr_sticky: got busy=%b ovr=%b expected 0 1", busy, overrun);
    end
  endtask

  task automatic test_reset_midstream();
    logic [255:0] a, b;
    int           cyc;
    a = rand256(); b = rand256();
    hash = a; ready = 1'b1; out_ready = 1'b1;
    step();
    ready = 1'b0; cyc = 0;
    while (mq.size() > 22 && cyc < 200) begin
      cyc++;
      out_ready = $urandom_range(0, 1);
      step();
    end
    n_vec++;
    if (out_data !== byte_of(a, 10)) begin
      n_err++; $display("FAIL rstmid_byte10: got %h expected %h", out_data, byte_of(a, 10));
    end
    #2 rst = 1'b0;
    #1;
    mq.delete(); movr = 1'b0;
    n_vec++;
    if (obs_vec() !== 12'h000) begin
      n_err++; $display("FAIL rstmid_async: got %h expected %h", obs_vec(), 12'h000);
    end
    step();
    step();
    rst = 1'b1;
    step();
    hash = b; ready = 1'b1; out_ready = 1'b0;
    step();
    ready = 1'b0;
    n_vec++;
    if ({out_valid, out_last, overrun, out_data} !== {3'b100, byte_of(b, 0)}) begin
      n_err++; $display("FAIL rstmid_restart: got v%b l%b ovr%b %h expected 1 0 0 %h",
                        out_valid, out_last, overrun, out_data, byte_of(b, 0));
    end
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      out_ready = $urandom_range(0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_drain cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      ready = ($urandom_range(0, 24) == 0);
      if (ready) hash = rand256();
      out_ready = ($urandom_range(0, 3) != 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random c=%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      step();
    end
    ready = 1'b0;
  endtask

  task automatic test_sha1_w32();
    logic [159:0] h;
    h = ABC160;
    hash1 = ABC160; ready1 = 1'b1; out_ready1 = 1'b1;
    step();
    ready1 = 1'b0; hash1 = '0;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({out_valid1, out_last1, out_data1} !== {1'b1, k == 4, h[159-32*k -: 32]}) begin
        n_err++; $display("FAIL sha1_word k=%0d: got v%b l%b %h expected v1 l%0d %h",
                          k, out_valid1, out_last1, out_data1, k == 4, h[159-32*k -: 32]);
      end
      step();
    end
    n_vec++;
    if ({out_valid1, busy1, overrun1} !== 3'b000) begin
      n_err++; $display("FAIL sha1_done: got v%b busy%b ovr%b expected 0 0 0", out_valid1, busy1, overrun1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    movr = 1'b0;
    test_reset();
    test_abc_stream();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_midstream();
    test_random();
    test_sha1_w32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
